// File: rtl/iob_vga_pkg.sv
// Default 640x480@60 timing constants and shared types for the VGA path.
// Latency: n/a (declarations only).
// Backpressure: n/a; the VGA pins never stall.
package iob_vga_pkg;

  // Pixel counters are 10 bits wide on the ports, so both totals must stay below 1024.
  localparam int CNT_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // The sync pulse covers [start, end] inclusive.
  localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  // Values driven onto the VGA connector, registered together.
  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } vga_pins_t;

  // Idle pin state: both syncs inactive (high) and black.
  localparam vga_pins_t PINS_IDLE = '{hs: 1'b1, vs: 1'b1, rgb: 12'h000};

  // Bits needed to hold values 0..max_val; never less than 1.
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) <= max_val) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/iob_vga_sync_cnt.sv
// Wrap counter 0..MAX used for the horizontal and vertical pixel positions.
// Latency: count updates on the clk after en; wrap is combinational in the same cycle as en.
// Backpressure: none; clr overrides en and returns the count to zero.
module vga_timing_cnt #(
  parameter int MAX = 799,
  parameter int W   = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // Wrap fires on the enabled step that takes the count from MAX back to zero.
  assign wrap = en && (cnt == MAX_V);

  // Count enabled steps, folding MAX back to zero; reset and clear both zero it.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/iob_vga_sync.sv
// VGA timing generator: pixel-rate divider, x/y counters, blanked and registered RGB/sync pins.
// Latency: pins show pixel (x,y) for the pixel period after the tick at which the counters equal (x,y).
// Backpressure: none; vga_en low idles the timing and restarts the frame at (0,0) when raised.
module iob_vga_sync
  import iob_vga_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_en,
  input  logic [11:0] rgb_in,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        video_on,
  output logic        pixel_tick,
  output logic        frame_start,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [11:0] vga_rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // A divide of 1 still gets a 1-bit divider that simply sits at zero.
  localparam int                DIV_W   = cnt_width(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(CLK_DIV - 1);

  localparam logic [CNT_W-1:0] H_ACT_V   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_V   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div;
  logic             h_wrap;
  logic             v_wrap;
  logic             hs_raw;
  logic             vs_raw;
  vga_pins_t        pins_q;
  vga_pins_t        pins_d;

  // Clock divider: counts clk cycles within one pixel period; disabled timing holds it at zero
  // so the first tick after enable lands exactly CLK_DIV cycles later.
  always_ff @(posedge clk) begin
    if (rst || !vga_en) begin
      div <= '0;
    end else if (div == DIV_MAX) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  assign pixel_tick = vga_en && (div == DIV_MAX);

  vga_timing_cnt #(
    .MAX (H_TOTAL - 1),
    .W   (CNT_W)
  ) u_h_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (pixel_tick),
    .clr  (!vga_en),
    .cnt  (pixel_x),
    .wrap (h_wrap)
  );

  vga_timing_cnt #(
    .MAX (V_TOTAL - 1),
    .W   (CNT_W)
  ) u_v_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (h_wrap),
    .clr  (!vga_en),
    .cnt  (pixel_y),
    .wrap (v_wrap)
  );

  // The vertical wrap only fires on the horizontal wrap of the last line: the last pixel of the frame.
  assign frame_start = v_wrap;

  assign video_on = (pixel_x < H_ACT_V) && (pixel_y < V_ACT_V);

  // Raw syncs from the current counters; they are low inside the pulse window.
  assign hs_raw = !((pixel_x >= HS_START) && (pixel_x <= HS_END));
  assign vs_raw = !((pixel_y >= VS_START) && (pixel_y <= VS_END));

  // Next pin state for the pixel currently addressed; blanking forces black outside the active area.
  always_comb begin
    pins_d     = PINS_IDLE;
    pins_d.hs  = hs_raw;
    pins_d.vs  = vs_raw;
    pins_d.rgb = video_on ? rgb_in : 12'h000;
  end

  // Output stage: capture syncs and colour once per pixel so rgb_in only matters at the tick.
  always_ff @(posedge clk) begin
    if (rst || !vga_en) begin
      pins_q <= PINS_IDLE;
    end else if (pixel_tick) begin
      pins_q <= pins_d;
    end
  end

  assign vga_hs  = pins_q.hs;
  assign vga_vs  = pins_q.vs;
  assign vga_rgb = pins_q.rgb;

endmodule

// File: tb/tb_iob_vga_sync.sv
// Bench for iob_vga_sync: two instances (divide 4 and divide 1) on a reduced 16x10 raster.
// Expected pin values are queued at each modelled pixel tick and popped one cycle later.
// A fixed vector table pins down hand-derived timing points of the divide-4 instance.
module tb_iob_vga_sync;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
  localparam int DA = 4, DB = 1;
  localparam int NV = 24;

  typedef struct {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } pins_t;

  typedef struct {
    int          cyc;
    int          x;
    int          y;
    logic        tick;
    logic        fs;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        vga_en;
  logic [11:0] rgb_in;

  logic [9:0]  x_a, y_a, x_b, y_b;
  logic        vo_a, vo_b, tick_a, tick_b, fs_a, fs_b, hs_a, hs_b, vs_a, vs_b;
  logic [11:0] rgb_a, rgb_b;

  int    tests, fails, rel;
  int    t0, t1;
  pins_t q0[$];
  pins_t q1[$];
  pins_t cur0, cur1;
  vec_t  tbl[NV];
  logic  tbl_on;

  iob_vga_sync #(
    .CLK_DIV(DA), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut_a (
    .clk(clk), .rst(rst), .vga_en(vga_en), .rgb_in(rgb_in),
    .pixel_x(x_a), .pixel_y(y_a), .video_on(vo_a), .pixel_tick(tick_a),
    .frame_start(fs_a), .vga_hs(hs_a), .vga_vs(vs_a), .vga_rgb(rgb_a)
  );

  iob_vga_sync #(
    .CLK_DIV(DB), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut_b (
    .clk(clk), .rst(rst), .vga_en(vga_en), .rgb_in(rgb_in),
    .pixel_x(x_b), .pixel_y(y_b), .video_on(vo_b), .pixel_tick(tick_b),
    .frame_start(fs_b), .vga_hs(hs_b), .vga_vs(vs_b), .vga_rgb(rgb_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s rel=%0d got=%0h expected=%0h", name, rel, got, exp);
    end
  endtask

  function automatic logic hs_exp(input int x);
    return !(x >= HA + HF && x < HA + HF + HS);
  endfunction

  function automatic logic vs_exp(input int y);
    return !(y >= VA + VF && y < VA + VF + VS);
  endfunction

  // Reference: register contents derive from t, the clk count since the last clear.
  task automatic model_check(input int id, input int d,
                             input logic [9:0] ax, input logic [9:0] ay,
                             input logic atick, input logic afs, input logic avo,
                             input logic ahs, input logic avs, input logic [11:0] argb);
    int    t, x, y;
    logic  tick, fs, vo;
    pins_t e, nxt;
    logic  push;
    string p;
    p = (id == 0) ? "a" : "b";
    t = (id == 0) ? t0 : t1;
    if (id == 0) begin
      if (q0.size() > 0) cur0 = q0.pop_front();
      e = cur0;
    end else begin
      if (q1.size() > 0) cur1 = q1.pop_front();
      e = cur1;
    end
    x    = (t / d) % HT;
    y    = (t / d) / HT;
    tick = vga_en && (t % d == d - 1);
    fs   = tick && x == HT - 1 && y == VT - 1;
    vo   = x < HA && y < VA;
    chk({p, ".pixel_x"}, int'(ax), x);
    chk({p, ".pixel_y"}, int'(ay), y);
    chk({p, ".pixel_tick"}, int'(atick), int'(tick));
    chk({p, ".frame_start"}, int'(afs), int'(fs));
    chk({p, ".video_on"}, int'(avo), int'(vo));
    chk({p, ".vga_hs"}, int'(ahs), int'(e.hs));
    chk({p, ".vga_vs"}, int'(avs), int'(e.vs));
    chk({p, ".vga_rgb"}, int'(argb), int'(e.rgb));
    push = 1'b0;
    nxt  = '{hs: 1'b1, vs: 1'b1, rgb: 12'h000};
    if (rst || !vga_en) begin
      push = 1'b1;
      t    = 0;
    end else begin
      if (tick) begin
        push = 1'b1;
        nxt  = '{hs: hs_exp(x), vs: vs_exp(y), rgb: vo ? rgb_in : 12'h000};
      end
      t = (t + 1) % (d * HT * VT);
    end
    if (id == 0) begin
      t0 = t;
      if (push) q0.push_back(nxt);
    end else begin
      t1 = t;
      if (push) q1.push_back(nxt);
    end
  endtask

  task automatic sample();
    #1;
    model_check(0, DA, x_a, y_a, tick_a, fs_a, vo_a, hs_a, vs_a, rgb_a);
    model_check(1, DB, x_b, y_b, tick_b, fs_b, vo_b, hs_b, vs_b, rgb_b);
    if (tbl_on) begin
      for (int i = 0; i < NV; i++) begin
        if (tbl[i].cyc == rel) begin
          chk("tbl.pixel_x", int'(x_a), tbl[i].x);
          chk("tbl.pixel_y", int'(y_a), tbl[i].y);
          chk("tbl.pixel_tick", int'(tick_a), int'(tbl[i].tick));
          chk("tbl.frame_start", int'(fs_a), int'(tbl[i].fs));
          chk("tbl.vga_hs", int'(hs_a), int'(tbl[i].hs));
          chk("tbl.vga_vs", int'(vs_a), int'(tbl[i].vs));
          chk("tbl.vga_rgb", int'(rgb_a), int'(tbl[i].rgb));
        end
      end
    end
  endtask

  task automatic adv();
    rel++;
    @(negedge clk);
  endtask

  initial begin
    int ticks, first_tick, first_fs, bticks;
    tests = 0; fails = 0; rel = 0; tbl_on = 1'b0;

    // Hand-derived points of the divide-4 instance, cycle 0 = first enabled cycle, rgb_in = ABC.
    //            cyc    x  y  tick  fs    hs    vs    rgb
    tbl[0]  = '{    0,  0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
    tbl[1]  = '{    3,  0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000};
    tbl[2]  = '{    4,  1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 12'hABC};
    tbl[3]  = '{    7,  1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 12'hABC};
    tbl[4]  = '{   35,  8, 0, 1'b1, 1'b0, 1'b1, 1'b1, 12'hABC};
    tbl[5]  = '{   36,  9, 0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
    tbl[6]  = '{   43, 10, 0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000};
    tbl[7]  = '{   44, 11, 0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000};
    tbl[8]  = '{   55, 13, 0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000};
    tbl[9]  = '{   56, 14, 0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
    tbl[10] = '{   64,  0, 1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
    tbl[11] = '{   68,  1, 1, 1'b0, 1'b0, 1'b1, 1'b1, 12'hABC};
    tbl[12] = '{  324,  1, 5, 1'b0, 1'b0, 1'b1, 1'b1, 12'hABC};
    tbl[13] = '{  388,  1, 6, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
    tbl[14] = '{  451,  0, 7, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000};
    tbl[15] = '{  452,  1, 7, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
    tbl[16] = '{  579,  0, 9, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000};
    tbl[17] = '{  580,  1, 9, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
    tbl[18] = '{  638, 15, 9, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
    tbl[19] = '{  639, 15, 9, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000};
    tbl[20] = '{  640,  0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
    tbl[21] = '{  644,  1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 12'hABC};
    tbl[22] = '{ 1278, 15, 9, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
    tbl[23] = '{ 1279, 15, 9, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000};

    rst = 1'b1; vga_en = 1'b0; rgb_in = 12'h000;
    @(negedge clk);
    @(negedge clk);
    t0 = 0; t1 = 0;
    cur0 = '{hs: 1'b1, vs: 1'b1, rgb: 12'h000};
    cur1 = '{hs: 1'b1, vs: 1'b1, rgb: 12'h000};

    // Reset state, then one idle cycle with the run enable low.
    sample(); adv();
    rst = 1'b0;
    sample(); adv();

    // Two full frames and part of a third with a constant colour.
    vga_en = 1'b1; rgb_in = 12'hABC; rel = 0; tbl_on = 1'b1;
    while (rel < 1495) begin
      sample(); adv();
    end
    tbl_on = 1'b0;

    // Drop the enable at x=5,y=3 on the cycle that would have ticked.
    vga_en = 1'b0;
    sample();
    chk("drop.tick_suppressed", int'(tick_a), 0);
    adv();
    ticks = 0;
    for (int k = 0; k < 10; k++) begin
      sample();
      if (k == 0) begin
        chk("drop.pixel_x", int'(x_a), 0);
        chk("drop.pixel_y", int'(y_a), 0);
        chk("drop.vga_hs", int'(hs_a), 1);
        chk("drop.vga_vs", int'(vs_a), 1);
        chk("drop.vga_rgb", int'(rgb_a), 0);
      end
      ticks += int'(tick_a) + int'(tick_b) + int'(fs_a) + int'(fs_b);
      adv();
    end
    chk("drop.no_ticks", ticks, 0);

    // Reassert: frame restarts from (0,0).
    vga_en = 1'b1; first_tick = -1; first_fs = -1;
    for (int r = 0; r < 700; r++) begin
      sample();
      if (tick_a && first_tick < 0) first_tick = r;
      if (fs_a && first_fs < 0) first_fs = r;
      adv();
    end
    chk("reen.first_tick", first_tick, DA - 1);
    chk("reen.first_frame_start", first_fs, DA * HT * VT - 1);

    // Colour changing every cycle; reset mid-line with enable high, later with enable low.
    bticks = 0;
    for (int k = 0; k < 200; k++) begin
      rgb_in = 12'($urandom);
      rst    = (k == 77) || (k == 150);
      vga_en = !(k >= 150 && k < 153);
      sample();
      if (k == 78) begin
        chk("rst.a.pixel_x", int'(x_a), 0);
        chk("rst.a.pixel_y", int'(y_a), 0);
        chk("rst.b.pixel_x", int'(x_b), 0);
        chk("rst.a.pins", int'({hs_a, vs_a, rgb_a}), 32'h3000);
        chk("rst.b.pins", int'({hs_b, vs_b, rgb_b}), 32'h3000);
      end
      if (k >= 100 && k < 120) bticks += int'(tick_b);
      adv();
    end
    chk("div1.tick_every_cycle", bticks, 20);

    rst = 1'b0; vga_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
